store_unit: RTL and testbench

Buffered store path of the memory pipeline, the write-side counterpart of the load unit. It accepts store operations from the issue stage, formats data and byte strobes for byte, half or word size, and holds them in a DEPTH-entry FIFO. It drains the FIFO to the memory bus through a req/ack handshake. It also provides an address-match check so the load path can stall on pending stores to the same word.

---
 rtl/store_unit.sv | 144 ++++++++++++++
 tb/tb_store_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Buffered store path: formats byte/half/word stores into a DEPTH-entry FIFO
// and drains it in program order over a req/ack write bus.
module store_unit #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        st_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] chk_addr,
    output logic        chk_hit,
    output logic        busy,
    output logic        empty
);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } entry_t;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    entry_t            r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_head, r_tail;
    logic [PW:0]       r_count;
    logic              r_err;
    state_t            r_state, w_state_nxt;

    logic              w_legal, w_acc, w_push, w_pop, w_hit;
    logic [3:0]        w_strb;
    logic [31:0]       w_data;
    logic [PW:0]       w_count_nxt;
    entry_t            w_head;
    logic              w_unused;

    assign w_unused = &{1'b0, chk_addr[1:0]};

    always_comb begin
        w_legal = 1'b0;
        w_strb  = 4'b0000;
        w_data  = st_data;
        case (st_size)
            2'b00: begin
                w_legal = 1'b1;
                w_strb  = 4'b0001 << st_addr[1:0];
                w_data  = {4{st_data[7:0]}};
            end
            2'b01: begin
                w_legal = ~st_addr[0];
                w_strb  = st_addr[1] ? 4'b1100 : 4'b0011;
                w_data  = {2{st_data[15:0]}};
            end
            2'b10: begin
                w_legal = (st_addr[1:0] == 2'b00);
                w_strb  = 4'b1111;
            end
            default: ;
        endcase
    end

    assign st_ready    = (r_count != (PW+1)'(DEPTH));
    assign w_acc       = st_valid && st_ready;
    assign w_push      = w_acc && w_legal;
    assign w_pop       = (r_state == S_REQ) && mem_ack;
    assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    assign w_head      = r_mem[r_head];

    // Payload storage carries no reset; r_vld and the output gating cover it.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= '{waddr: st_addr[31:2], wdata: w_data, wstrb: w_strb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_acc && !w_legal;
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_head        <= r_head + 1'b1;
                r_vld[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail        <= r_tail + 1'b1;
                r_vld[r_tail] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_count != '0) w_state_nxt = S_REQ;
            S_REQ:  if (w_pop && w_count_nxt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (r_state == S_REQ) begin
            mem_req   = 1'b1;
            mem_addr  = {w_head.waddr, 2'b00};
            mem_wdata = w_head.wdata;
            mem_wstrb = w_head.wstrb;
        end
    end

    // The in-flight head is still valid here, so loads stall until its ack.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (r_vld[i] && r_mem[i].waddr == chk_addr[31:2]) w_hit = 1'b1;
    end

    assign chk_hit = w_hit;
    assign st_err  = r_err;
    assign busy    = (r_count != '0);
    assign empty   = (r_count == '0);
endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios then random traffic,
// compared each cycle against a queue-based model of the store buffer.
module tb_store_unit;
    localparam int DEPTH = 4;

    logic        clk = 0, rst_n = 0;
    logic        st_valid = 0, st_ready, st_err;
    logic [31:0] st_addr = 0, st_data = 0;
    logic [1:0]  st_size = 0;
    logic        mem_req, mem_ack = 0;
    logic [31:0] mem_addr, mem_wdata, chk_addr = 0;
    logic [3:0]  mem_wstrb;
    logic        chk_hit, busy, empty;

    store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_err(st_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .chk_addr(chk_addr),
        .chk_hit(chk_hit), .busy(busy), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          legal;
    } ent_t;

    ent_t q[$];
    bit   m_req, m_err, last_acc;
    int   total = 0, bad = 0;

    function automatic ent_t fmt(logic [31:0] a, logic [31:0] d, logic [1:0] s);
        ent_t e;
        e.addr = {a[31:2], 2'b00};
        case (s)
            2'd0: begin e.legal = 1; e.strb = 4'(1 << a[1:0]); e.data = {4{d[7:0]}}; end
            2'd1: begin e.legal = (a % 2 == 0); e.strb = (a % 4 >= 2) ? 4'hC : 4'h3;
                        e.data = {2{d[15:0]}}; end
            2'd2: begin e.legal = (a % 4 == 0); e.strb = 4'hF; e.data = d; end
            default: begin e.legal = 0; e.strb = 0; e.data = 0; end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit hit = 0;
        foreach (q[i]) if (q[i].addr[31:2] == chk_addr[31:2]) hit = 1;
        chk("st_ready", st_ready, q.size() != DEPTH);
        chk("busy", busy, q.size() != 0);
        chk("empty", empty, q.size() == 0);
        chk("st_err", st_err, m_err);
        chk("chk_hit", chk_hit, hit);
        chk("mem_req", mem_req, m_req);
        chk("mem_addr", mem_addr, m_req ? q[0].addr : 32'h0);
        chk("mem_wdata", mem_wdata, m_req ? q[0].data : 32'h0);
        chk("mem_wstrb", mem_wstrb, m_req ? q[0].strb : 4'h0);
    endtask

    // Check at negedge, advance the model on the posedge, then return 1ns later.
    task automatic step();
        ent_t e;
        int   old_sz;
        bit   pop;
        @(negedge clk);
        check_all();
        @(posedge clk);
        old_sz   = q.size();
        last_acc = st_valid && (old_sz != DEPTH);
        e        = fmt(st_addr, st_data, st_size);
        pop      = m_req && mem_ack;
        if (pop) void'(q.pop_front());
        if (last_acc && e.legal) q.push_back(e);
        m_err = last_acc && !e.legal;
        if (m_req) m_req = pop ? (q.size() != 0) : 1'b1;
        else       m_req = (old_sz != 0);
        #1;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_valid = 1; st_addr = a; st_data = d; st_size = s;
    endtask

    initial begin
        #3;
        check_all();
        chk("rst_ready", st_ready, 1);
        #5 rst_n = 1;
        #1;

        // byte store
        mem_ack = 1;
        put(32'h1003, 32'hAB, 2'd0);
        step();
        st_valid = 0;
        step();
        chk("byte_req", mem_req, 1);
        chk("byte_addr", mem_addr, 32'h1000);
        chk("byte_strb", mem_wstrb, 4'b1000);
        chk("byte_wdata", mem_wdata, 32'hABABABAB);
        step(); step();
        chk("byte_empty", empty, 1);

        // half and word formatting
        put(32'h2002, 32'h1234, 2'd1);
        step();
        put(32'h2004, 32'hDEADBEEF, 2'd2);
        step();
        st_valid = 0;
        chk("half_strb", mem_wstrb, 4'b1100);
        chk("half_wdata", mem_wdata, 32'h12341234);
        step();
        chk("word_strb", mem_wstrb, 4'b1111);
        chk("word_wdata", mem_wdata, 32'hDEADBEEF);
        repeat (3) step();

        // illegal stores
        put(32'h2001, 32'h55, 2'd1);
        step();
        chk("ill_err1", st_err, 1);
        put(32'h2000, 32'h66, 2'd3);
        step();
        chk("ill_err2", st_err, 1);
        st_valid = 0;
        step();
        chk("ill_err_end", st_err, 0);
        chk("ill_noreq", mem_req, 0);
        chk("ill_empty", empty, 1);

        // full / backpressure
        mem_ack = 0;
        for (int i = 0; i < 4; i++) begin
            put(32'h4000 + 4 * i, 32'h100 + i, 2'd2);
            step();
        end
        chk("full_ready", st_ready, 0);
        put(32'h4010, 32'h104, 2'd2);
        step(); step();
        chk("full_held", last_acc, 0);
        mem_ack = 1;
        last_acc = 0;
        for (int k = 0; k < 10 && !last_acc; k++) step();
        chk("full_5th_acc", last_acc, 1);
        st_valid = 0;
        repeat (8) step();
        chk("full_drained", empty, 1);

        // address match
        mem_ack = 0;
        put(32'h3000, 32'h1, 2'd2); step();
        put(32'h3008, 32'h2, 2'd2); step();
        st_valid = 0;
        chk_addr = 32'h3001; step();
        chk("hit_3001", chk_hit, 1);
        chk_addr = 32'h3004; step();
        chk("hit_3004", chk_hit, 0);
        chk_addr = 32'h3008;
        mem_ack = 1;
        repeat (4) step();
        chk("hit_after", chk_hit, 0);

        // reset mid-drain
        mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            put(32'h5000 + 4 * i, 32'h200 + i, 2'd2);
            step();
        end
        st_valid = 0;
        step();
        chk("pre_rst_req", mem_req, 1);
        #1 rst_n = 0;
        #1;
        chk("rst_req_drop", mem_req, 0);
        chk("rst_empty", empty, 1);
        q.delete(); m_req = 0; m_err = 0;
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1;
        repeat (4) step();
        chk("rst_noreq", mem_req, 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            st_valid = ($urandom_range(0, 2) != 0);
            st_addr  = 32'h3000 + $urandom_range(0, 63);
            st_data  = $urandom;
            st_size  = 2'($urandom_range(0, 3));
            mem_ack  = (n % 64 < 20) ? 1'b0 : 1'($urandom_range(0, 1));
            chk_addr = 32'h3000 + $urandom_range(0, 63);
            step();
        end
        st_valid = 0;
        mem_ack  = 1;
        repeat (10) step();
        chk("final_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
